calc_executor: RTL and testbench

CALC_EXECUTOR -- requirements
Module: calc_executor

---
 rtl/calc_executor.sv | 158 +++++++++++++++
 tb/tb_calc_executor.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_executor.sv
// Staged calculator executor: operand capture, start detect and an
// add/sub single-cycle or mul/div 8-iteration shift datapath.
module calc_executor (
  input  logic        clk,
  input  logic        reset,
  input  logic        en1,
  input  logic        en2,
  input  logic        en3,
  input  logic [7:0]  sw,
  input  logic [1:0]  op_sel,
  output logic [15:0] result,
  output logic        result_valid,
  output logic        busy,
  output logic        div_by_zero,
  output logic        negative
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        en3_q;
  logic        armed;
  logic [1:0]  op;
  logic [15:0] wa;
  logic [7:0]  wb;
  logic [15:0] acc;
  logic [2:0]  cnt;
  logic        start;
  logic [15:0] nacc;
  logic [15:0] nwa;
  logic [7:0]  nwb;
  logic [8:0]  trial;

  // armed keeps a held-high en3 across reset release from starting
  assign start = en3 & ~en3_q & ~en1 & ~en2 & armed;

  // operand registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a <= '0;
      b <= '0;
    end else begin
      if (en1) a <= sw;
      if (en2) b <= sw;
    end
  end

  // en3 edge history and arming after reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en3_q <= 1'b0;
      armed <= 1'b0;
    end else begin
      en3_q <= en3;
      if (!en3) armed <= 1'b1;
    end
  end

  // one shift-add or restoring-divide iteration
  always_comb begin
    nacc  = acc;
    nwa   = wa;
    nwb   = wb;
    trial = '0;
    if (op == 2'b10) begin
      nacc = acc + (wb[0] ? wa : 16'd0);
      nwa  = {wa[14:0], 1'b0};
      nwb  = {1'b0, wb[7:1]};
    end else begin
      trial = {acc[7:0], wa[7]};
      nwa   = {wa[14:0], 1'b0};
      if (trial >= {1'b0, wb}) begin
        nacc   = {7'd0, trial - {1'b0, wb}};
        nwa[0] = 1'b1;
      end else begin
        nacc = {7'd0, trial};
      end
    end
  end

  // control FSM with registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      op           <= '0;
      wa           <= '0;
      wb           <= '0;
      acc          <= '0;
      cnt          <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      busy         <= 1'b0;
      div_by_zero  <= 1'b0;
      negative     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          op          <= op_sel;
          div_by_zero <= 1'b0;
          negative    <= 1'b0;
          wa          <= {8'd0, a};
          wb          <= b;
          acc         <= '0;
          cnt         <= '0;
          unique case (1'b1)
            op_sel == 2'b00: begin
              result       <= {7'd0, {1'b0, a} + {1'b0, b}};
              result_valid <= 1'b1;
              state        <= DONE;
            end
            op_sel == 2'b01: begin
              result       <= {8'd0, a} - {8'd0, b};
              negative     <= a < b;
              result_valid <= 1'b1;
              state        <= DONE;
            end
            op_sel == 2'b11 && b == 8'd0: begin
              result       <= 16'hFFFF;
              div_by_zero  <= 1'b1;
              result_valid <= 1'b1;
              state        <= DONE;
            end
            default: begin
              busy  <= 1'b1;
              state <= BUSY;
            end
          endcase
        end
        BUSY: begin
          if (!en3) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            acc <= nacc;
            wa  <= nwa;
            wb  <= nwb;
            cnt <= cnt + 3'd1;
            if (cnt == 3'd7) begin
              result       <= (op == 2'b10) ? nacc
                                            : {nacc[7:0], nwa[7:0]};
              busy         <= 1'b0;
              result_valid <= 1'b1;
              state        <= DONE;
            end
          end
        end
        DONE: if (en1) begin
          result_valid <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_executor.sv
// Scoreboard bench for calc_executor: expected results queued at start,
// compared when result_valid rises.
module tb_calc_executor;

  logic        clk = 1'b0;
  logic        reset;
  logic        en1;
  logic        en2;
  logic        en3;
  logic [7:0]  sw;
  logic [1:0]  op_sel;
  logic [15:0] result;
  logic        result_valid;
  logic        busy;
  logic        div_by_zero;
  logic        negative;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [17:0] sb[$];
  logic [15:0] last_res = '0;

  calc_executor dut (
    .clk          (clk),
    .reset        (reset),
    .en1          (en1),
    .en2          (en2),
    .en3          (en3),
    .sw           (sw),
    .op_sel       (op_sel),
    .result       (result),
    .result_valid (result_valid),
    .busy         (busy),
    .div_by_zero  (div_by_zero),
    .negative     (negative)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [17:0] model(logic [7:0] a, logic [7:0] b,
                                        logic [1:0] op);
    logic [15:0] r;
    logic        dz;
    logic        ng;
    dz = 1'b0;
    ng = 1'b0;
    r  = '0;
    case (op)
      2'd0: r = 16'(a) + 16'(b);
      2'd1: begin
        r  = 16'(a) - 16'(b);
        ng = a < b;
      end
      2'd2: r = 16'(a) * 16'(b);
      default:
        if (b == 8'd0) begin
          r  = 16'hFFFF;
          dz = 1'b1;
        end else begin
          r = {8'(a % b), 8'(a / b)};
        end
    endcase
    return {ng, dz, r};
  endfunction

  task automatic load(logic [7:0] a, logic [7:0] b);
    en1 = 1'b1;
    sw  = a;
    tick();
    en1 = 1'b0;
    en2 = 1'b1;
    sw  = b;
    tick();
    en2 = 1'b0;
  endtask

  task automatic fire(logic [1:0] op);
    op_sel = op;
    en3    = 1'b1;
    tick();
  endtask

  task automatic collect(string tag, int lat);
    int          n;
    int          bc;
    logic [17:0] e;
    n  = 1;
    bc = 0;
    while (!result_valid && n < 30) begin
      if (busy) bc++;
      tick();
      n++;
    end
    check({tag, "_lat"}, n, lat);
    check({tag, "_busycyc"}, bc, lat - 1);
    check({tag, "_busy"}, busy, 0);
    if (sb.size() == 0) begin
      check({tag, "_sb"}, 0, 1);
    end else begin
      e = sb.pop_front();
      check({tag, "_res"}, result, e[15:0]);
      check({tag, "_dbz"}, div_by_zero, e[16]);
      check({tag, "_neg"}, negative, e[17]);
      last_res = e[15:0];
    end
  endtask

  task automatic run(logic [7:0] a, logic [7:0] b, logic [1:0] op,
                     string tag);
    load(a, b);
    sb.push_back(model(a, b, op));
    fire(op);
    collect(tag, (op == 2'd2 || (op == 2'd3 && b != 8'd0)) ? 9 : 1);
    en3 = 1'b0;
  endtask

  initial begin
    reset  = 1'b1;
    en1    = 1'b0;
    en2    = 1'b0;
    en3    = 1'b0;
    sw     = '0;
    op_sel = '0;
    tick();
    tick();
    check("rst_res", result, 0);
    check("rst_valid", result_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_dbz", div_by_zero, 0);
    check("rst_neg", negative, 0);
    reset = 1'b0;
    tick();

    run(8'd200, 8'd100, 2'd0, "add");
    run(8'd5,   8'd9,   2'd1, "sub_neg");
    run(8'd9,   8'd5,   2'd1, "sub_pos");
    run(8'd255, 8'd255, 2'd2, "mul");
    run(8'd100, 8'd7,   2'd3, "div");
    run(8'd42,  8'd0,   2'd3, "div0");
    run(8'd0,   8'd0,   2'd2, "mul0");
    run(8'd255, 8'd1,   2'd3, "div1");
    run(8'd3,   8'd200, 2'd3, "divsmall");
    for (int i = 0; i < 6; i++)
      run(8'($urandom), 8'($urandom), 2'($urandom), "rnd");

    en3 = 1'b1;
    tick();
    check("done_ign_valid", result_valid, 1);
    check("done_ign_busy", busy, 0);
    check("done_ign_res", result, last_res);
    en3 = 1'b0;

    en1 = 1'b1;
    sw  = 8'd3;
    tick();
    en1 = 1'b0;
    check("cyc_valid", result_valid, 0);
    check("cyc_res", result, last_res);
    en2 = 1'b1;
    sw  = 8'd4;
    tick();
    en2 = 1'b0;
    sb.push_back(model(8'd3, 8'd4, 2'd0));
    fire(2'd0);
    collect("cyc_newA", 1);
    en3 = 1'b0;

    load(8'd10, 8'd20);
    fire(2'd2);
    tick();
    tick();
    tick();
    en3 = 1'b0;
    tick();
    check("abort_busy", busy, 0);
    check("abort_valid", result_valid, 0);
    check("abort_res", result, last_res);
    tick();
    tick();
    check("abort_stay", result_valid | busy, 0);

    load(8'd255, 8'd255);
    fire(2'd2);
    tick();
    tick();
    reset = 1'b1;
    #1;
    check("rstb_res", result, 0);
    check("rstb_valid", result_valid, 0);
    check("rstb_busy", busy, 0);
    check("rstb_flags", {div_by_zero, negative}, 0);
    tick();
    reset = 1'b0;
    tick();
    tick();
    check("rstb_nostart", result_valid | busy, 0);
    en3 = 1'b0;
    tick();
    run(8'd12, 8'd13, 2'd2, "post_rst");

    en1 = 1'b1;
    sw  = 8'd1;
    tick();
    en1 = 1'b0;
    tick();
    en1    = 1'b1;
    en2    = 1'b1;
    en3    = 1'b1;
    op_sel = 2'd0;
    sw     = 8'd6;
    tick();
    check("ill_valid", result_valid, 0);
    check("ill_busy", busy, 0);
    en1 = 1'b0;
    en2 = 1'b0;
    en3 = 1'b0;
    tick();
    sb.push_back(model(8'd6, 8'd6, 2'd0));
    fire(2'd0);
    collect("ill_load", 1);
    en3 = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
